cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//  Miss-fill controller for the L1 I/D caches (16-byte block, 8 x 16-bit words, 64 sets).
//  On a miss it latches the address and issues 8 pipelined word reads to main memory.
//  For each returned word it drives the word offset and the set index that the cache's
//  one-hot word/set decoders consume, and writes that word into the data array.
//  It then writes the tag array once and releases the pipeline stall.
// PARAMETERS
//  ADDR_W    16  byte-address width
//  WORDS     8   words per block; must be a power of two (WORDS = 2**OFF_W)
//  OFF_W     3   word-offset width
//  IDX_W     6   set-index width
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       synchronous, active-high reset
//  miss_detected    in   1       cache lookup missed this cycle
//  miss_address     in   ADDR_W  byte address of the missing access
//  memory_data_vld  in   1       main memory returns one word this cycle, in request order
//  fsm_busy         out  1       stall pipeline / mux cache ports to fill path
//  memory_read      out  1       issue one read request this cycle
//  memory_address   out  ADDR_W  request address, valid while memory_read = 1
//  word_offset      out  OFF_W   word being written; to the 8-way word decoder
//  fill_index       out  IDX_W   set being filled; to the 64-way set decoder
//  fill_tag         out  ADDR_W-IDX_W-OFF_W-1  tag to write = latched addr[15:10]
//  write_data_array out  1       write the current memory word at word_offset/fill_index
//  write_tag_array  out  1       write fill_tag and set valid at fill_index
//  fill_done        out  1       one-cycle pulse, same cycle as write_tag_array
// BEHAVIOUR
//  Reset: state = IDLE; req_cnt = 0; rsp_cnt = 0; latched address = 0.
//   All outputs are 0 (word_offset = 0, fill_index = 0, fill_tag = 0).
//  Address split: tag = [15:10], index = [9:4], word = [3:1], byte = [0].
//  States:
//   IDLE:   if miss_detected -> latch miss_address, clear counters, go to REQ.
//   REQ:    memory_read = 1. memory_address = {lat[15:4], req_cnt, 1'b0}.
//           req_cnt++ each cycle. Go to WAIT after issuing req_cnt = WORDS-1.
//   WAIT:   no requests. Go to FINISH when the WORDS-th response is accepted.
//   FINISH: write_tag_array = fill_done = 1 for one cycle, then go to IDLE.
//  Response handling (REQ and WAIT only):
//   - write_data_array = memory_data_vld, combinational.
//   - word_offset = rsp_cnt; rsp_cnt++ on each valid.
//   - If the last response arrives while in REQ (impossible for a memory latency >= 1),
//     the FSM still goes to FINISH only after all requests are issued.
//  fsm_busy = (state != IDLE). It is registered, so it rises the cycle after the miss.
//  fill_index and fill_tag come from the latched address and are stable for the whole fill.
//  Counters are OFF_W+1 bits wide, so the compare with WORDS does not wrap.
//   The request address uses only the low OFF_W bits.
//  Ignored inputs:
//   - miss_detected while busy, including in FINISH.
//   - memory_data_vld in IDLE or FINISH, and any valid after WORDS responses.
//   These never assert write_data_array.
//  A miss in the cycle after FINISH (state = IDLE) is accepted normally; back-to-back fills are legal.
//  rst asserted mid-fill: next cycle is IDLE with all outputs 0.
//   Partially written words are left as-is; the tag is not written, so the line stays invalid.
//  Throughput: one request and one write per cycle. Total fill = WORDS + mem_latency + 2 cycles.
// TESTING
//  1. Miss at cycle 0, addr 0xABC6, memory latency 4:
//     memory_read in cycles 1-8, addresses 0xABC0,0xABC2,...,0xABCE.
//     Writes in cycles 5-12 with word_offset 0..7; fill_index = 0x3C; fill_tag = 0x2A.
//     write_tag_array/fill_done in cycle 13; fsm_busy = 1 in cycles 1-13.
//  2. Reset mid-fill (rst at cycle 6 of test 1):
//     cycle 7: IDLE, fsm_busy = 0, no tag write.
//     A new miss at 0x0010 then fills cleanly with index 1.
//  3. miss_detected held high for the whole of test 1:
//     only one fill runs. A second fill starts the cycle after fill_done (IDLE sees the miss).
//  4. Irregular responses: gaps between memory_data_vld pulses plus 2 extra valids after the 8th:
//     exactly 8 writes with offsets 0..7, and the extras are ignored.
//  5. Back-to-back misses 0xFFFE then 0x0000:
//     addresses wrap within the block (0xFFF0..0xFFFE), no carry into the tag.
//     Second fill uses index 0, tag 0.
//  6. memory_data_vld pulsed in IDLE: write_data_array stays 0 and the state does not change.

Source files
------------

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Miss-fill controller for the L1 I/D caches. On a miss it
//               latches the block address and issues one pipelined word read
//               per cycle to main memory. Each returned word is written into
//               the data array at the current word offset and set index.
//               The tag array is written once at the end and the pipeline
//               stall is released.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
    parameter int ADDR_W = 16,  // byte-address width
    parameter int WORDS  = 8,   // words per block, equal to 2**OFF_W
    parameter int OFF_W  = 3,   // word-offset width
    parameter int IDX_W  = 6    // set-index width
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            miss_detected,
    input  logic [ADDR_W-1:0]               miss_address,
    input  logic                            memory_data_vld,
    output logic                            fsm_busy,
    output logic                            memory_read,
    output logic [ADDR_W-1:0]               memory_address,
    output logic [OFF_W-1:0]                word_offset,
    output logic [IDX_W-1:0]                fill_index,
    output logic [ADDR_W-IDX_W-OFF_W-2:0]   fill_tag,
    output logic                            write_data_array,
    output logic                            write_tag_array,
    output logic                            fill_done
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    // Address layout: { tag | index | word | byte }, byte field is one bit.
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 1;
    // Block-aligned part of the address that must be kept for the fill.
    localparam int BLK_W = ADDR_W - OFF_W - 1;
    // One extra counter bit so that "all WORDS seen" is representable.
    localparam int CNT_W = OFF_W + 1;

    localparam logic [CNT_W-1:0] C_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] C_CNT_WORDS = CNT_W'(WORDS);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;  // waiting for a miss
    localparam logic [1:0] S_REQ    = 2'd1;  // issuing word reads
    localparam logic [1:0] S_WAIT   = 2'd2;  // all reads issued, draining
    localparam logic [1:0] S_FINISH = 2'd3;  // tag write, one cycle

    // ------------------------------------------------------------------------
    // Registers and internal wires
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    // Block address of the miss; the word/byte bits are regenerated from
    // the request counter, so only the block-aligned part is stored.
    logic [BLK_W-1:0]  r_blk_addr;

    // Number of read requests issued in this fill.
    logic [CNT_W-1:0]  r_req_cnt;
    // Number of responses accepted in this fill.
    logic [CNT_W-1:0]  r_rsp_cnt;

    logic              w_in_fill_window;
    logic              w_rsp_accept;
    logic              w_last_rsp;
    logic              w_all_rsp_seen;
    logic              w_last_req;
    logic              w_miss_accept;

    // Word and byte bits of the miss address do not affect the fill: the
    // whole block is fetched starting from word 0.
    logic              w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, miss_address[OFF_W:0]};

    // ------------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------------
    // Responses are only meaningful while reads can be outstanding; valids
    // in IDLE or FINISH, and any beyond the WORDS-th, are dropped.
    assign w_in_fill_window = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_rsp_accept     = memory_data_vld && w_in_fill_window
                              && (r_rsp_cnt < C_CNT_WORDS);
    assign w_last_rsp       = w_rsp_accept && (r_rsp_cnt == C_CNT_LAST);
    assign w_all_rsp_seen   = (r_rsp_cnt == C_CNT_WORDS);
    assign w_last_req       = (r_state == S_REQ) && (r_req_cnt == C_CNT_LAST);
    assign w_miss_accept    = (r_state == S_IDLE) && miss_detected;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Holds the fill phase; reset returns to IDLE from any point of a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // REQ always runs its full WORDS cycles before WAIT, so even a response
    // stream that completes during REQ cannot skip ahead of the requests.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (miss_detected) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (w_last_req) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_last_rsp || w_all_rsp_seen) begin
                    w_next_state = S_FINISH;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Fill datapath: latched block address and request/response counters
    // ------------------------------------------------------------------------
    // The block address is captured once per accepted miss and then held,
    // which keeps fill_index / fill_tag stable for the entire fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_addr <= '0;
            r_req_cnt  <= C_CNT_ZERO;
            r_rsp_cnt  <= C_CNT_ZERO;
        end else begin
            if (w_miss_accept) begin
                r_blk_addr <= miss_address[ADDR_W-1:OFF_W+1];
                r_req_cnt  <= C_CNT_ZERO;
                r_rsp_cnt  <= C_CNT_ZERO;
            end else begin
                if (r_state == S_REQ) begin
                    r_req_cnt <= r_req_cnt + C_CNT_ONE;
                end
                if (w_rsp_accept) begin
                    r_rsp_cnt <= r_rsp_cnt + C_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    // Request address keeps the block part fixed and walks the word field,
    // so the offset never carries into index or tag.
    always_comb begin
        fsm_busy         = (r_state != S_IDLE);
        memory_read      = (r_state == S_REQ);
        memory_address   = '0;
        if (r_state == S_REQ) begin
            memory_address = {r_blk_addr, r_req_cnt[OFF_W-1:0], 1'b0};
        end
        write_data_array = w_rsp_accept;
        word_offset      = r_rsp_cnt[OFF_W-1:0];
        fill_index       = r_blk_addr[IDX_W-1:0];
        fill_tag         = r_blk_addr[BLK_W-1:IDX_W];
        write_tag_array  = (r_state == S_FINISH);
        fill_done        = (r_state == S_FINISH);
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Self-checking bench for cache_fill_fsm. A transaction-level
//               reference model predicts each cycle's outputs from the fill
//               start cycle, the miss address and the count of accepted
//               memory responses. A small memory model returns words in
//               order after a configurable latency with optional gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_vld;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic [2:0]  word_offset;
    logic [5:0]  fill_index;
    logic [5:0]  fill_tag;
    logic        write_data_array;
    logic        write_tag_array;
    logic        fill_done;

    cache_fill_fsm #(
        .ADDR_W (16),
        .WORDS  (8),
        .OFF_W  (3),
        .IDX_W  (6)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_vld  (memory_data_vld),
        .fsm_busy         (fsm_busy),
        .memory_read      (memory_read),
        .memory_address   (memory_address),
        .word_offset      (word_offset),
        .fill_index       (fill_index),
        .fill_tag         (fill_tag),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .fill_done        (fill_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model of the fill in progress
    bit          m_active = 1'b0;   // a miss has been accepted, fill not over
    int          m_start  = 0;      // cycle in which the miss was accepted
    int          m_done   = -1;     // cycle of the tag write, once known
    int          m_acc    = 0;      // responses accepted so far
    logic [15:0] m_lat    = 16'h0;  // address of the last accepted miss

    // Memory / stimulus knobs
    int          mem_q[$];          // due cycles of outstanding reads
    int          lat        = 4;
    int          gap_pct    = 0;
    int          extra_left = 0;
    bit          idle_noise = 1'b0;
    bit          miss_drv   = 1'b0;
    logic [15:0] addr_drv   = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, update models.
    task automatic tick(input bit do_rst);
        bit          vld;
        int          k;
        bit          e_read, e_wr, e_busy, e_done;
        logic [15:0] e_addr;
        logic [2:0]  k3;
        vld = 1'b0;
        if (!do_rst) begin
            if (mem_q.size() > 0 && mem_q[0] <= cyc && $urandom_range(0, 99) >= gap_pct) begin
                vld = 1'b1;
                void'(mem_q.pop_front());
            end else if (mem_q.size() == 0 && m_acc >= 8 && extra_left > 0) begin
                vld = 1'b1;
                extra_left--;
            end else if (idle_noise && !m_active && $urandom_range(0, 1) == 1) begin
                vld = 1'b1;
            end
        end
        rst             = do_rst;
        memory_data_vld = vld;
        miss_detected   = miss_drv;
        miss_address    = addr_drv;
        @(negedge clk);
        if (do_rst) begin
            m_active = 1'b0;
            m_lat    = 16'h0;
            m_acc    = 0;
            m_done   = -1;
            mem_q.delete();
        end else begin
            k      = m_active ? (cyc - m_start - 1) : -1;
            e_read = (k >= 0) && (k < 8);
            k3     = k[2:0];
            e_addr = e_read ? {m_lat[15:4], k3, 1'b0} : 16'h0;
            e_busy = (k >= 0) && (m_done < 0 || cyc <= m_done);
            e_done = m_active && (cyc == m_done);
            e_wr   = vld && (k >= 0) && (m_acc < 8);
            chk("busy",      32'(fsm_busy),         32'(e_busy));
            chk("mem_read",  32'(memory_read),      32'(e_read));
            chk("mem_addr",  32'(memory_address),   32'(e_addr));
            chk("wr_data",   32'(write_data_array), 32'(e_wr));
            chk("word_off",  32'(word_offset),      32'(m_acc % 8));
            chk("fill_idx",  32'(fill_index),       32'(m_lat[9:4]));
            chk("fill_tag",  32'(fill_tag),         32'(m_lat[15:10]));
            chk("wr_tag",    32'(write_tag_array),  32'(e_done));
            chk("fill_done", 32'(fill_done),        32'(e_done));
            if (memory_read) mem_q.push_back(cyc + lat);
            if (e_wr) begin
                m_acc++;
                if (m_acc == 8) m_done = (cyc + 1 > m_start + 10) ? cyc + 1 : m_start + 10;
            end
            if (m_active && cyc == m_done) begin
                m_active = 1'b0;
            end else if (!m_active && miss_drv) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_lat    = addr_drv;
                m_acc    = 0;
                m_done   = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Run until the model's fill completes, bounded by a cycle budget.
    task automatic wait_fill(input int budget);
        int i = 0;
        while (m_active && i < budget) begin
            tick(1'b0);
            i++;
        end
        chk("fill_timeout", 32'(m_active), 32'(0));
    endtask

    task automatic start_miss(input logic [15:0] a);
        miss_drv = 1'b1;
        addr_drv = a;
        tick(1'b0);
        miss_drv = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        miss_detected   = 1'b0;
        miss_address    = 16'h0;
        memory_data_vld = 1'b0;
        tick(1'b1);
        tick(1'b1);
        // Reset state
        tick(1'b0);
        tick(1'b0);

        // Basic fill, latency 4, misaligned address
        lat = 4;
        start_miss(16'hABC6);
        wait_fill(100);
        tick(1'b0);

        // Reset in the middle of a fill, then a clean fill at index 1
        start_miss(16'hABC6);
        for (int i = 0; i < 5; i++) tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        start_miss(16'h0010);
        wait_fill(100);
        tick(1'b0);

        // Miss held high: one fill, then a second starting right after done
        miss_drv = 1'b1;
        addr_drv = 16'hABC6;
        tick(1'b0);
        wait_fill(100);
        tick(1'b0);
        miss_drv = 1'b0;
        wait_fill(100);
        tick(1'b0);

        // Irregular responses with two extra valids after the last word
        lat        = 3;
        gap_pct    = 50;
        extra_left = 2;
        start_miss(16'h1234);
        wait_fill(300);
        for (int i = 0; i < 6; i++) tick(1'b0);
        gap_pct    = 0;
        extra_left = 0;

        // Back-to-back fills at the top and bottom of the address space
        lat      = 2;
        miss_drv = 1'b1;
        addr_drv = 16'hFFFE;
        tick(1'b0);
        addr_drv = 16'h0000;
        wait_fill(100);
        tick(1'b0);
        miss_drv = 1'b0;
        wait_fill(100);
        tick(1'b0);

        // Spurious memory valids while idle
        idle_noise = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b0);
        idle_noise = 1'b0;

        // Randomized fills
        for (int n = 0; n < 25; n++) begin
            lat        = $urandom_range(1, 6);
            gap_pct    = $urandom_range(0, 60);
            extra_left = $urandom_range(0, 3);
            idle_noise = ($urandom_range(0, 3) == 0);
            start_miss(16'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                for (int i = 0; i < int'($urandom_range(0, 12)); i++) tick(1'b0);
                tick(1'b1);
            end else begin
                wait_fill(400);
            end
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) tick(1'b0);
        end
        idle_noise = 1'b0;
        extra_left = 0;
        for (int i = 0; i < 4; i++) tick(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
